// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops. Each cycle every bit behaves as a D, T, JK or SR flop,
// selected by mode. Also keeps sticky SR-illegal flags and a saturating count of cycles in which q changed.
module multi_mode_ff_bank #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] err_mask,
  output logic             chg,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_err;
  logic             r_chg;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_err_set;
  logic [WIDTH-1:0] w_err_next;
  logic             w_changed;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_q_next  = r_q;
    w_err_set = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode)
          MODE_D:  w_q_next[i] = a[i];
          MODE_T:  if (a[i]) w_q_next[i] = ~r_q[i];
          MODE_JK: begin
            case ({a[i], b[i]})
              2'b01:   w_q_next[i] = 1'b0;
              2'b10:   w_q_next[i] = 1'b1;
              2'b11:   w_q_next[i] = ~r_q[i];
              default: w_q_next[i] = r_q[i];
            endcase
          end
          MODE_SR: begin
            // S=R=1 is illegal for an SR flop: hold the bit and flag it instead.
            case ({a[i], b[i]})
              2'b01:   w_q_next[i] = 1'b0;
              2'b10:   w_q_next[i] = 1'b1;
              2'b11:   w_err_set[i] = 1'b1;
              default: w_q_next[i] = r_q[i];
            endcase
          end
          default: w_q_next[i] = r_q[i];
        endcase
      end
    end
    // A new illegal condition survives a simultaneous clear.
    w_err_next = err_clr ? w_err_set : (r_err | w_err_set);
    w_changed  = (w_q_next != r_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= INIT;
      r_err <= '0;
      r_chg <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q_next;
      r_err <= w_err_next;
      r_chg <= w_changed;
      if (w_changed) r_cnt <= sat_inc(r_cnt);
    end
  end

  assign q        = r_q;
  assign q_n      = ~r_q;
  assign err_mask = r_err;
  assign chg      = r_chg;
  assign chg_cnt  = r_cnt;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Bench for multi_mode_ff_bank: two instances (default params, and INIT=8'h3C/CNT_W=2)
// driven by shared stimulus and checked against a behavioural model.
module tb_multi_mode_ff_bank;

  localparam logic [7:0] INIT1 = 8'h3C;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       en;
  logic [7:0] a, b;
  logic       err_clr;

  logic [7:0] q0, qn0, em0, cnt0;
  logic       chg0;
  logic [7:0] q1, qn1, em1;
  logic [1:0] cnt1;
  logic       chg1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_q   [2];
  logic [7:0] m_err [2];
  logic       m_chg [2];
  int         m_cnt [2];
  int         m_max [2];

  always #5 clk = ~clk;

  multi_mode_ff_bank #(.WIDTH(8), .INIT(8'h00), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .mode(mode), .en(en), .a(a), .b(b), .err_clr(err_clr),
    .q(q0), .q_n(qn0), .err_mask(em0), .chg(chg0), .chg_cnt(cnt0)
  );

  multi_mode_ff_bank #(.WIDTH(8), .INIT(INIT1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .mode(mode), .en(en), .a(a), .b(b), .err_clr(err_clr),
    .q(q1), .q_n(qn1), .err_mask(em1), .chg(chg1), .chg_cnt(cnt1)
  );

  // Characteristic equations of the four flop types, applied to the whole vector.
  function automatic logic [7:0] model_next(input logic [1:0] md, input logic e,
                                            input logic [7:0] s, input logic [7:0] r,
                                            input logic [7:0] cur);
    if (!e) return cur;
    case (md)
      2'd0:    return s;
      2'd1:    return cur ^ s;
      2'd2:    return (s & ~cur) | (~r & cur);
      default: return (s & ~r) | (cur & ~(s ^ r));
    endcase
  endfunction

  task automatic model_reset();
    m_q[0] = 8'h00; m_q[1] = INIT1;
    for (int k = 0; k < 2; k++) begin
      m_err[k] = '0; m_chg[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  // Advance one clock edge, update the model, and leave time at posedge+1.
  task automatic step();
    logic [7:0] nq, ill;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        nq  = model_next(mode, en, a, b, m_q[k]);
        ill = (en && mode == 2'd3) ? (a & b) : 8'h00;
        m_err[k] = err_clr ? ill : (m_err[k] | ill);
        m_chg[k] = (nq != m_q[k]);
        if (m_chg[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
        m_q[k] = nq;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mode = 2'($urandom); en = 1'b1; a = 8'($urandom); b = 8'($urandom);
    err_clr = 1'b0;
    model_reset();
    step(); step();
    n_checks++; if (q0 !== 8'h00)  begin n_fail++; $display("FAIL reset_q0 got %h want %h", q0, 8'h00); end
    n_checks++; if (qn0 !== 8'hFF) begin n_fail++; $display("FAIL reset_qn0 got %h want %h", qn0, 8'hFF); end
    n_checks++; if (q1 !== INIT1)  begin n_fail++; $display("FAIL reset_q1 got %h want %h", q1, INIT1); end
    n_checks++; if (qn1 !== ~INIT1) begin n_fail++; $display("FAIL reset_qn1 got %h want %h", qn1, ~INIT1); end
    n_checks++; if (em0 !== 8'h00 || chg0 !== 1'b0 || cnt0 !== 8'h00)
      begin n_fail++; $display("FAIL reset_ctl0 got em=%h chg=%b cnt=%h want 0", em0, chg0, cnt0); end
    reset = 1'b1;
  endtask

  task automatic test_toggle();
    mode = 2'd1; en = 1'b1; a = 8'h0F; b = 8'($urandom);
    step();
    n_checks++; if (q0 !== 8'h0F || chg0 !== 1'b1)
      begin n_fail++; $display("FAIL toggle1 got q=%h chg=%b want 0f 1", q0, chg0); end
    step();
    n_checks++; if (q0 !== 8'h00 || chg0 !== 1'b1)
      begin n_fail++; $display("FAIL toggle2 got q=%h chg=%b want 00 1", q0, chg0); end
    n_checks++; if (cnt0 !== 8'd2) begin n_fail++; $display("FAIL toggle_cnt got %0d want 2", cnt0); end
    n_checks++; if (q1 !== m_q[1]) begin n_fail++; $display("FAIL toggle_q1 got %h want %h", q1, m_q[1]); end
  endtask

  task automatic test_d_hold();
    mode = 2'd0; en = 1'b1; a = 8'hA5;
    step();
    n_checks++; if (q0 !== 8'hA5 || qn0 !== 8'h5A)
      begin n_fail++; $display("FAIL d_load got q=%h qn=%h want a5 5a", q0, qn0); end
    en = 1'b0; a = 8'hFF; b = 8'hFF; mode = 2'd3;
    step();
    n_checks++; if (q0 !== 8'hA5 || chg0 !== 1'b0 || em0 !== 8'h00)
      begin n_fail++; $display("FAIL en_hold got q=%h chg=%b em=%h want a5 0 00", q0, chg0, em0); end
  endtask

  task automatic test_jk();
    mode = 2'd2; en = 1'b1; a = 8'hF0; b = 8'h0F;
    step();
    n_checks++; if (q0 !== 8'hF0) begin n_fail++; $display("FAIL jk_setclr got %h want f0", q0); end
    a = 8'hFF; b = 8'hFF;
    step();
    n_checks++; if (q0 !== 8'h0F) begin n_fail++; $display("FAIL jk_toggle got %h want 0f", q0); end
  endtask

  task automatic test_sr();
    mode = 2'd3; en = 1'b1; a = 8'h81; b = 8'h81;
    step();
    n_checks++; if (q0 !== 8'h0F || em0 !== 8'h81)
      begin n_fail++; $display("FAIL sr_illegal got q=%h em=%h want 0f 81", q0, em0); end
    a = 8'h00; b = 8'h00;
    step();
    n_checks++; if (em0 !== 8'h81) begin n_fail++; $display("FAIL sr_sticky got %h want 81", em0); end
    err_clr = 1'b1; a = 8'h02; b = 8'h02;
    step();
    err_clr = 1'b0;
    n_checks++; if (em0 !== 8'h02 || q0 !== 8'h0F)
      begin n_fail++; $display("FAIL sr_clr_setwins got em=%h q=%h want 02 0f", em0, q0); end
    n_checks++; if (em1 !== m_err[1]) begin n_fail++; $display("FAIL sr_em1 got %h want %h", em1, m_err[1]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      mode = 2'(i % 4); en = 1'b1; a = 8'($urandom); b = 8'($urandom);
      step();
      n_checks++; if (q0 !== m_q[0] || q1 !== m_q[1])
        begin n_fail++; $display("FAIL b2b_q[%0d] got %h/%h want %h/%h", i, q0, q1, m_q[0], m_q[1]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      mode = 2'($urandom); en = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); err_clr = ($urandom_range(0, 7) == 0);
      step();
      n_checks++; if (q0 !== m_q[0] || qn0 !== ~m_q[0] || q1 !== m_q[1] || qn1 !== ~m_q[1])
        begin n_fail++; $display("FAIL rnd_q[%0d] got %h/%h want %h/%h", i, q0, q1, m_q[0], m_q[1]); end
      n_checks++; if (em0 !== m_err[0] || em1 !== m_err[1])
        begin n_fail++; $display("FAIL rnd_err[%0d] got %h/%h want %h/%h", i, em0, em1, m_err[0], m_err[1]); end
      n_checks++; if (chg0 !== m_chg[0] || chg1 !== m_chg[1])
        begin n_fail++; $display("FAIL rnd_chg[%0d] got %b/%b want %b/%b", i, chg0, chg1, m_chg[0], m_chg[1]); end
      n_checks++; if (int'(cnt0) != m_cnt[0] || int'(cnt1) != m_cnt[1])
        begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, cnt0, cnt1, m_cnt[0], m_cnt[1]); end
    end
    err_clr = 1'b0;
  endtask

  task automatic test_sat_async_reset();
    // Mid-cycle asynchronous reset, held across a clock edge with live inputs.
    #2 reset = 1'b0; model_reset();
    #1;
    n_checks++; if (q0 !== 8'h00 || q1 !== INIT1 || cnt0 !== 8'h00 || cnt1 !== 2'd0)
      begin n_fail++; $display("FAIL async_rst1 got q=%h/%h cnt=%0d/%0d want 00/3c 0/0", q0, q1, cnt0, cnt1); end
    mode = 2'd0; en = 1'b1; a = 8'hFF;
    step();
    n_checks++; if (q0 !== 8'h00 || q1 !== INIT1 || em0 !== 8'h00 || chg0 !== 1'b0)
      begin n_fail++; $display("FAIL rst_hold got q=%h/%h em=%h chg=%b", q0, q1, em0, chg0); end
    #2 reset = 1'b1;
    mode = 2'd1; a = 8'h01;
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (cnt1 !== 2'd3 || cnt0 !== 8'd5)
      begin n_fail++; $display("FAIL cnt_sat got %0d/%0d want 3/5", cnt1, cnt0); end
    n_checks++; if (q1 !== (INIT1 ^ 8'h01)) begin n_fail++; $display("FAIL t5_q1 got %h want %h", q1, INIT1 ^ 8'h01); end
    #2 reset = 1'b0; model_reset();
    #1;
    n_checks++; if (q1 !== INIT1 || cnt1 !== 2'd0 || chg1 !== 1'b0 || q0 !== 8'h00)
      begin n_fail++; $display("FAIL async_rst2 got q=%h/%h cnt1=%0d chg1=%b", q0, q1, cnt1, chg1); end
    @(negedge clk); reset = 1'b1;
    mode = 2'd0; a = 8'h55;
    step();
    n_checks++; if (q0 !== 8'h55 || q1 !== 8'h55 || chg1 !== 1'b1 || cnt1 !== 2'd1)
      begin n_fail++; $display("FAIL post_rst got q=%h/%h chg1=%b cnt1=%0d want 55/55 1 1", q0, q1, chg1, cnt1); end
  endtask

  initial begin
    m_max[0] = 255; m_max[1] = 3;
    test_reset();
    test_toggle();
    test_d_hold();
    test_jk();
    test_sr();
    test_back_to_back();
    test_random();
    test_sat_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
